calc_keypad_ctrl: RTL and testbench
===================================

# calc_keypad_ctrl

Parametrised keypad-driven calculator controller, successor to the two-register keypad state machine. It sits between the hex keypad scanner and the display driver. It debounces raw key codes, accumulates decimal digit entry into one of NREG operand registers, and executes ADD/SUB/AND/OR/XOR on key release. It reports the selected register, an overflow/borrow flag and a one-cycle completion pulse.

## Interface
- WIDTH, 8: operand/register width in bits (≥4).
- NREG, 2: number of operand registers (≥1); SELW = max(1, clog2(NREG)).
- DEBOUNCE, 4: consecutive identical samples needed to accept a key or a release (≥1).

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- key  in  5  keypad code: key[4]=1 means no key (KEY_NONE=5'h10); otherwise key[3:0]: 0–9 digit, A select-next, B ADD, C SUB, D AND, E OR, F XOR.
- disp  out  WIDTH  contents of R[sel].
- sel  out  SELW  currently selected register.
- st  out  2  FSM state code.
- ovf  out  1  overflow/borrow flag of last digit or operation.
- done  out  1  one-cycle pulse, operation result written.

## Operation
- Reset: all R[i]=0, sel=0, st=S_WPR, ovf=0, done=0; debounce history cleared (last=KEY_NONE, count=0).
- Debounce: a "stable event" with value v fires on the edge that samples v for the DEBOUNCE-th consecutive time. Any change of key restarts the count. Further identical samples fire no new event.
- Every key[4]=1 value is treated as KEY_NONE.
- States: S_WPR (wait press), S_GON (wait release after digit/select), S_OP (wait release after op key), S_EXE (one-cycle execute).
- S_WPR, stable digit d:
  - If R[sel]*10+d < 2^WIDTH, then R[sel] <= R[sel]*10+d and ovf <= 0.
  - Otherwise R[sel] is unchanged and ovf <= 1.
  - Next state S_GON.
- S_WPR, stable A: sel <= (sel+1) mod NREG; next state S_GON.
- S_WPR, stable B–F: latch opcode; next state S_OP.
- S_WPR, stable NONE: no action.
- S_GON: on stable NONE, go to S_WPR. Any other key is ignored.
- S_OP: on stable NONE, go to S_EXE. Any other key is ignored; the opcode stays as latched.
- S_EXE: src = R[(sel+1) mod NREG] (equal to R[sel] when NREG=1). R[sel] <= R[sel] op src, computed mod 2^WIDTH. done=1 for this cycle. Next state S_WPR.
  - ADD: ovf = carry out.
  - SUB: ovf = borrow (R[sel] < src).
  - AND/OR/XOR: ovf = 0.
- Only R[sel] is ever written; sel does not change in S_GON, S_OP or S_EXE.

## Timing
- Digit or select acts on the edge of the stable event; disp reflects the new value in the following cycle.
- Op latency: release stable event at edge N moves the FSM to S_EXE. done is high during cycle N..N+1. R[sel] and ovf update at edge N+1, and st returns to S_WPR at that edge.
- Minimum full keystroke: 2·DEBOUNCE cycles for a digit or select, 2·DEBOUNCE+1 cycles for an operation.
- Reset has priority over everything. rst in S_OP or S_EXE aborts the operation: no write, done=0.
- Key held indefinitely produces exactly one action. A new press without an intervening stable NONE is never accepted.
- Digit multiply is computed as (R<<3)+(R<<1)+d at WIDTH+4 bits before the range check.

## Structure
- Shared defines header `defines.h`:
  - state codes S_WPR=0, S_GON=1, S_OP=2, S_EXE=3;
  - KEY_NONE and KEY_0..KEY_9, KEY_A..KEY_F;
  - opcode encodings OP_ADD..OP_XOR.
- Sub-module `key_debounce` (parameters DEBOUNCE and key width; outputs stable value and a one-cycle event pulse). The FSM, register file and ALU stay in the top module.

## Test plan
(WIDTH=8, NREG=2, DEBOUNCE=3; each key held 3 cycles, then NONE for 3 cycles.)
- Digit entry: after reset, keys 1,2,5 → R0=125, disp=8'h7D, ovf=0, sel=0.
- Digit overflow: R0=125, then key 9 → R0 stays 125, ovf=1. Next key 0 is also rejected (1250), ovf=1.
- ADD with carry:
  - A → sel=1; digits 200; A → sel=0; B → R0=69 (8'h45), ovf=1.
  - done high exactly one cycle, on the cycle after the third NONE sample.
- SUB borrow and XOR: R0=5, R1=7, C → R0=254, ovf=1. Then R0=8'hF0, R1=8'h3C, F → R0=8'hCC, ovf=0.
- Bounce rejection: key 3 for 2 cycles, key 4 for 1 cycle, NONE → no register or state change. Key 7 held 20 cycles → a single digit applied.
- Reset mid-op: op key B accepted (st=S_OP), then rst before release → all registers 0, st=S_WPR, done never asserted.

Source files
------------

// File: rtl/calc_keypad_ctrl_pkg.sv
// Shared definitions for the keypad calculator: FSM state codes, key codes,
// opcode encodings and small key-classification helpers.
package calc_keypad_ctrl_pkg;

  // Key code width as delivered by the keypad scanner
  localparam int KEYW = 5;

  // FSM state codes, visible on the st output
  typedef enum logic [1:0] {
    S_WPR = 2'd0,
    S_GON = 2'd1,
    S_OP  = 2'd2,
    S_EXE = 2'd3
  } state_t;

  // Latched operation selected by keys B..F
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } op_t;

  localparam logic [KEYW-1:0] KEY_NONE = 5'h10;
  localparam logic [KEYW-1:0] KEY_0    = 5'h00;
  localparam logic [KEYW-1:0] KEY_1    = 5'h01;
  localparam logic [KEYW-1:0] KEY_2    = 5'h02;
  localparam logic [KEYW-1:0] KEY_3    = 5'h03;
  localparam logic [KEYW-1:0] KEY_4    = 5'h04;
  localparam logic [KEYW-1:0] KEY_5    = 5'h05;
  localparam logic [KEYW-1:0] KEY_6    = 5'h06;
  localparam logic [KEYW-1:0] KEY_7    = 5'h07;
  localparam logic [KEYW-1:0] KEY_8    = 5'h08;
  localparam logic [KEYW-1:0] KEY_9    = 5'h09;
  localparam logic [KEYW-1:0] KEY_A    = 5'h0A;
  localparam logic [KEYW-1:0] KEY_B    = 5'h0B;
  localparam logic [KEYW-1:0] KEY_C    = 5'h0C;
  localparam logic [KEYW-1:0] KEY_D    = 5'h0D;
  localparam logic [KEYW-1:0] KEY_E    = 5'h0E;
  localparam logic [KEYW-1:0] KEY_F    = 5'h0F;

  // Any code with bit 4 set means "no key"; fold them all onto KEY_NONE so the
  // debouncer sees a single idle value.
  function automatic logic [KEYW-1:0] norm_key(input logic [KEYW-1:0] k);
    return k[4] ? KEY_NONE : k;
  endfunction

  function automatic logic is_digit(input logic [KEYW-1:0] k);
    logic r;
    case (k)
      KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
      KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction

  // Maps an operation key (B..F) to its opcode
  function automatic op_t key_to_op(input logic [KEYW-1:0] k);
    op_t r;
    case (k)
      KEY_B:   r = OP_ADD;
      KEY_C:   r = OP_SUB;
      KEY_D:   r = OP_AND;
      KEY_E:   r = OP_OR;
      KEY_F:   r = OP_XOR;
      default: r = OP_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_keypad_ctrl_if.sv
// Keypad-side and display-side signals of the calculator controller.
// The keypad/driver side uses the master modport, the controller the slave one.
interface calc_keypad_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int SELW  = 1
);
  logic [4:0]       key;
  logic [WIDTH-1:0] disp;
  logic [SELW-1:0]  sel;
  logic [1:0]       st;
  logic             ovf;
  logic             done;

  modport master (
    output key,
    input  disp, sel, st, ovf, done
  );

  modport slave (
    input  key,
    output disp, sel, st, ovf, done
  );
endinterface

// File: rtl/calc_keypad_ctrl_key_debounce.sv
// Key debouncer: raises a one-cycle pulse on the edge where the same key code
// has been sampled for the DEBOUNCE-th consecutive time. Any change restarts
// the run; a run that keeps going never fires again.
module key_debounce #(
  parameter int              DEBOUNCE = 4,
  parameter int              KW       = 5,
  parameter logic [KW-1:0]   IDLE     = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [KW-1:0] key,
  output logic [KW-1:0] stable,
  output logic          pulse
);

  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] FIRE_AT  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] SAT      = CW'(DEBOUNCE);
  localparam logic          ONE_SHOT = (DEBOUNCE == 1);

  logic [KW-1:0] last;
  logic [CW-1:0] count;
  logic          same;

  assign same   = (key == last);
  assign stable = key;
  // The pulse is combinational so the consumer acts on the very edge that
  // takes the final confirming sample.
  assign pulse  = same ? (count == FIRE_AT) : ONE_SHOT;

  // Track the current run of identical samples, saturating once confirmed
  always_ff @(posedge clk) begin
    if (rst) begin
      last  <= IDLE;
      count <= '0;
    end else if (!same) begin
      last  <= key;
      count <= CW'(1);
    end else if (count != SAT) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/calc_keypad_ctrl.sv
// Keypad calculator controller: debounced key entry, decimal accumulation into
// NREG operand registers and ADD/SUB/AND/OR/XOR executed on key release.
module calc_keypad_ctrl #(
  parameter int WIDTH    = 8,
  parameter int NREG     = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic              clk,
  input  logic              rst,
  calc_keypad_ctrl_if.slave bus
);
  import calc_keypad_ctrl_pkg::*;

  localparam int SELW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [KEYW-1:0]  key_n;
  logic [KEYW-1:0]  stable_key;
  logic             key_evt;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] regs [NREG];
  logic [SELW-1:0]  sel, sel_inc, sel_nxt;
  op_t              op, op_nxt;
  logic             ovf, ovf_nxt;
  logic             reg_we;
  logic [WIDTH-1:0] reg_wdata;
  logic             done_c;

  logic [WIDTH-1:0] cur, src;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH:0]   alu_wide;
  logic [WIDTH+3:0] cur_ext, prod;
  logic             digit_ok;

  assign key_n = norm_key(bus.key);

  key_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .KW       (KEYW),
    .IDLE     (KEY_NONE)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .key    (key_n),
    .stable (stable_key),
    .pulse  (key_evt)
  );

  // The "other" register is the next one round-robin; with one register it
  // wraps back onto the selected register itself.
  assign sel_inc = (sel == SELW'(NREG - 1)) ? '0 : sel + 1'b1;
  assign cur     = regs[sel];
  assign src     = regs[sel_inc];

  // R*10 + d as shift-and-add, with four spare bits so the range check sees
  // the true product.
  assign cur_ext  = {4'b0000, cur};
  assign prod     = (cur_ext << 3) + (cur_ext << 1) + {{WIDTH{1'b0}}, stable_key[3:0]};
  assign digit_ok = (prod[WIDTH+3:WIDTH] == 4'b0000);

  // ALU on R[sel] and its neighbour; carry/borrow come out of the extra bit
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_wide = {1'b0, cur} + {1'b0, src};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_ovf  = alu_wide[WIDTH];
      end
      OP_SUB: begin
        alu_wide = {1'b0, cur} - {1'b0, src};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_ovf  = alu_wide[WIDTH];
      end
      OP_AND:  alu_res = cur & src;
      OP_OR:   alu_res = cur | src;
      OP_XOR:  alu_res = cur ^ src;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic and register-file/flag updates for each key phase
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    op_nxt    = op;
    ovf_nxt   = ovf;
    reg_we    = 1'b0;
    reg_wdata = cur;
    done_c    = 1'b0;
    case (state)
      S_WPR: begin
        if (key_evt && stable_key != KEY_NONE) begin
          if (is_digit(stable_key)) begin
            if (digit_ok) begin
              reg_we    = 1'b1;
              reg_wdata = prod[WIDTH-1:0];
              ovf_nxt   = 1'b0;
            end else begin
              ovf_nxt   = 1'b1;
            end
            state_nxt = S_GON;
          end else if (stable_key == KEY_A) begin
            sel_nxt   = sel_inc;
            state_nxt = S_GON;
          end else begin
            op_nxt    = key_to_op(stable_key);
            state_nxt = S_OP;
          end
        end
      end
      S_GON: begin
        if (key_evt && stable_key == KEY_NONE) state_nxt = S_WPR;
      end
      S_OP: begin
        if (key_evt && stable_key == KEY_NONE) state_nxt = S_EXE;
      end
      S_EXE: begin
        reg_we    = 1'b1;
        reg_wdata = alu_res;
        ovf_nxt   = alu_ovf;
        done_c    = 1'b1;
        state_nxt = S_WPR;
      end
      default: state_nxt = S_WPR;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_WPR;
    else     state <= state_nxt;
  end

  // Register file, selection, flag and latched opcode
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      sel <= '0;
      ovf <= 1'b0;
      op  <= OP_ADD;
    end else begin
      if (reg_we) regs[sel] <= reg_wdata;
      sel <= sel_nxt;
      ovf <= ovf_nxt;
      op  <= op_nxt;
    end
  end

  // A reset landing during execute cancels the completion pulse as well
  assign bus.disp = cur;
  assign bus.sel  = sel;
  assign bus.st   = state;
  assign bus.ovf  = ovf;
  assign bus.done = done_c & ~rst;

endmodule

// File: tb/tb_calc_keypad_ctrl.sv
// Testbench for calc_keypad_ctrl: directed keystroke scenarios plus random key
// streams, all compared cycle by cycle against a behavioural calculator model.
module tb_calc_keypad_ctrl;

  localparam int WIDTH    = 8;
  localparam int NREG     = 2;
  localparam int DEBOUNCE = 3;
  localparam int SELW     = 1;
  localparam logic [4:0] NONE = 5'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  calc_keypad_ctrl_if #(.WIDTH(WIDTH), .SELW(SELW)) bus ();

  calc_keypad_ctrl #(
    .WIDTH    (WIDTH),
    .NREG     (NREG),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errCount   = 0;
  int doneCount  = 0;

  // Behavioural model: plain integer registers, a run-length of equal samples
  // and flags describing where in the press/release cycle the user is.
  int mR [NREG];
  int mSel, mOvf, mOp;
  bit mHold, mOpPend, mExec;
  int runKey, runLen;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NREG; i++) mR[i] = 0;
    mSel = 0; mOvf = 0; mOp = 11;
    mHold = 0; mOpPend = 0; mExec = 0;
    runKey = 16; runLen = 0;
  endtask

  task automatic modelExecute();
    int a, b, r;
    a = mR[mSel];
    b = mR[(mSel + 1) % NREG];
    r = 0;
    mOvf = 0;
    case (mOp)
      11: begin r = a + b; mOvf = (r >= 256) ? 1 : 0; end
      12: begin r = a - b + 256; mOvf = (a < b) ? 1 : 0; end
      13: r = a & b;
      14: r = a | b;
      default: r = a ^ b;
    endcase
    mR[mSel] = r % 256;
  endtask

  task automatic modelStep(input logic [4:0] kin);
    int k;
    bit ev;
    k = kin[4] ? 16 : int'(kin);
    if (k == runKey) begin
      if (runLen <= DEBOUNCE) runLen++;
    end else begin
      runKey = k;
      runLen = 1;
    end
    ev = (runLen == DEBOUNCE);
    if (mExec) begin
      modelExecute();
      mExec = 0;
    end else if (mHold) begin
      if (ev && k == 16) begin
        mHold = 0;
        if (mOpPend) begin
          mOpPend = 0;
          mExec   = 1;
        end
      end
    end else if (ev && k != 16) begin
      mHold = 1;
      if (k < 10) begin
        if (mR[mSel] * 10 + k < 256) begin
          mR[mSel] = mR[mSel] * 10 + k;
          mOvf = 0;
        end else begin
          mOvf = 1;
        end
      end else if (k == 10) begin
        mSel = (mSel + 1) % NREG;
      end else begin
        mOp = k;
        mOpPend = 1;
      end
    end
  endtask

  task automatic checkAll();
    int expSt;
    expSt = mExec ? 3 : (mHold ? (mOpPend ? 2 : 1) : 0);
    if (bus.done === 1'b1) doneCount++;
    checkOutput("disp", 32'(bus.disp), 32'(mR[mSel]));
    checkOutput("sel",  32'(bus.sel),  32'(mSel));
    checkOutput("st",   32'(bus.st),   32'(expSt));
    checkOutput("ovf",  32'(bus.ovf),  32'(mOvf));
    checkOutput("done", 32'(bus.done), 32'(mExec));
  endtask

  // Drive one key code for n cycles, stepping the model on every edge
  task automatic applyStimulus(input logic [4:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      bus.key = k;
      @(posedge clk);
      if (rst) modelReset();
      else     modelStep(k);
      #1;
      checkAll();
    end
  endtask

  task automatic pressKey(input logic [4:0] k);
    applyStimulus(k, DEBOUNCE);
    applyStimulus(NONE, DEBOUNCE + 1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(NONE, 1);
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] rk;
    int hold;
    bus.key = NONE;
    modelReset();

    // reset state
    rst = 1'b1;
    applyStimulus(NONE, 2);
    checkOutput("reset_disp", 32'(bus.disp), 0);
    checkOutput("reset_st",   32'(bus.st),   0);
    rst = 1'b0;

    // digit entry 1,2,5
    pressKey(5'h01); pressKey(5'h02); pressKey(5'h05);
    checkOutput("entry_disp", 32'(bus.disp), 32'h7D);
    checkOutput("entry_ovf",  32'(bus.ovf),  0);
    checkOutput("entry_sel",  32'(bus.sel),  0);

    // digit overflow: 1259 and 1250 both rejected
    pressKey(5'h09);
    checkOutput("ovf9_disp", 32'(bus.disp), 125);
    checkOutput("ovf9_flag", 32'(bus.ovf),  1);
    pressKey(5'h00);
    checkOutput("ovf0_disp", 32'(bus.disp), 125);
    checkOutput("ovf0_flag", 32'(bus.ovf),  1);

    // ADD with carry: R1=200, R0=125
    pressKey(5'h0A);
    checkOutput("sel_next", 32'(bus.sel), 1);
    pressKey(5'h02); pressKey(5'h00); pressKey(5'h00);
    checkOutput("r1_disp", 32'(bus.disp), 200);
    pressKey(5'h0A);
    checkOutput("sel_wrap", 32'(bus.sel), 0);
    doneCount = 0;
    applyStimulus(5'h0B, DEBOUNCE);
    checkOutput("add_st_op", 32'(bus.st), 2);
    applyStimulus(NONE, DEBOUNCE - 1);
    checkOutput("add_no_early_done", 32'(doneCount), 0);
    applyStimulus(NONE, 1);
    checkOutput("add_done_pulse", 32'(bus.done), 1);
    applyStimulus(NONE, 1);
    checkOutput("add_done_clear", 32'(bus.done), 0);
    checkOutput("add_disp", 32'(bus.disp), 69);
    checkOutput("add_ovf",  32'(bus.ovf),  1);
    checkOutput("add_done_count", 32'(doneCount), 1);

    // SUB with borrow: 5 - 7
    doReset();
    pressKey(5'h05); pressKey(5'h0A); pressKey(5'h07); pressKey(5'h0A);
    pressKey(5'h0C);
    checkOutput("sub_disp", 32'(bus.disp), 254);
    checkOutput("sub_ovf",  32'(bus.ovf),  1);

    // XOR: F0 ^ 3C
    doReset();
    pressKey(5'h02); pressKey(5'h04); pressKey(5'h00); pressKey(5'h0A);
    pressKey(5'h06); pressKey(5'h00); pressKey(5'h0A);
    pressKey(5'h0F);
    checkOutput("xor_disp", 32'(bus.disp), 32'hCC);
    checkOutput("xor_ovf",  32'(bus.ovf),  0);

    // bounce rejection, then a long hold giving a single digit
    doReset();
    applyStimulus(5'h03, 2);
    applyStimulus(5'h04, 1);
    applyStimulus(NONE, DEBOUNCE + 1);
    checkOutput("bounce_disp", 32'(bus.disp), 0);
    checkOutput("bounce_st",   32'(bus.st),   0);
    applyStimulus(5'h07, 20);
    applyStimulus(NONE, DEBOUNCE + 1);
    checkOutput("hold_disp", 32'(bus.disp), 7);

    // reset while an operation waits for release
    pressKey(5'h0A);
    pressKey(5'h04);
    doneCount = 0;
    applyStimulus(5'h0B, DEBOUNCE);
    checkOutput("abort_st_op", 32'(bus.st), 2);
    doReset();
    checkOutput("abort_st",   32'(bus.st),   0);
    checkOutput("abort_disp", 32'(bus.disp), 0);
    applyStimulus(NONE, 2 * DEBOUNCE);
    pressKey(5'h0A);
    checkOutput("abort_r1", 32'(bus.disp), 0);
    checkOutput("abort_no_done", 32'(doneCount), 0);

    // random key streams with occasional resets
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 60) == 0) doReset();
      rk   = 5'($urandom_range(0, 31));
      hold = int'($urandom_range(1, 6));
      applyStimulus(rk, hold);
    end
    applyStimulus(NONE, 2 * DEBOUNCE);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
